// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared command, state and halt-reason codes for the pipeline run/step controller.
package pipeline_run_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_RUN    = 3'd1,
        CMD_STEP   = 3'd2,
        CMD_STEP_N = 3'd3,
        CMD_HALT   = 3'd4
    } cmd_e;

    typedef enum logic [2:0] {
        ST_HALTED   = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEP     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_FINISHED = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RSN_NONE = 2'd0,
        RSN_BP   = 2'd1,
        RSN_USER = 2'd2,
        RSN_END  = 2'd3
    } reason_e;

    // A single breakpoint slot still needs a 1-bit index port.
    function automatic int bp_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipeline_run_ctrl_bp_match.sv
// PC breakpoint table: per-slot address/enable registers, parallel compare against
// the fetch PC and lowest-index priority encode of the matching slots.
module bp_match
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int NB    = 32,
    parameter int NB_BP = 4,
    localparam int IW   = bp_idx_width(NB_BP)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_bp_we,
    input  logic [IW-1:0] i_bp_idx,
    input  logic [NB-1:0] i_bp_addr,
    input  logic          i_bp_en,
    input  logic [NB-1:0] i_pc,
    output logic          o_hit,
    output logic [IW-1:0] o_hit_idx
);

    logic [NB-1:0]    addr_q [NB_BP];
    logic [NB_BP-1:0] en_q;

    // Only the enables need a reset; a disabled slot's address is never compared.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            en_q <= '0;
        end else if (i_bp_we && (int'(i_bp_idx) < NB_BP)) begin
            addr_q[i_bp_idx] <= i_bp_addr;
            en_q[i_bp_idx]   <= i_bp_en;
        end
    end

    // Scan high to low so the lowest matching slot is the one left standing.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        for (int i = NB_BP - 1; i >= 0; i--) begin
            if (en_q[i] && (addr_q[i] == i_pc)) begin
                o_hit     = 1'b1;
                o_hit_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step controller for the 5-stage pipeline: free run, N-cycle step, breakpoints,
// user halt and drain-on-HALT. Breakpoints exist only with PIPELINE_BREAKPOINTS_EN defined.
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int NB           = 32,
    parameter int NB_BP        = 4,
    parameter int NB_CNT       = 32,
    parameter int DRAIN_CYCLES = 4,
    localparam int IW          = bp_idx_width(NB_BP)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [2:0]        i_cmd,
    input  logic [NB-1:0]     i_cmd_arg,
    output logic              o_cmd_ready,
    input  logic              i_bp_we,
    input  logic [IW-1:0]     i_bp_idx,
    input  logic [NB-1:0]     i_bp_addr,
    input  logic              i_bp_en,
    input  logic [NB-1:0]     i_pc,
    input  logic              i_halt_instr,
    output logic              o_step,
    output logic              o_pc_write,
    output logic [2:0]        o_state,
    output logic [1:0]        o_halt_reason,
    output logic [IW-1:0]     o_bp_hit_idx,
    output logic [NB_CNT-1:0] o_cycle_count,
    output logic              o_done
);

    state_e            state_q, state_d;
    reason_e           reason_q, reason_d;
    logic [IW-1:0]     hit_idx_q, hit_idx_d;
    logic [NB-1:0]     remain_q, remain_d;
    logic              skip_q, skip_d;
    logic              done_q, done_d;
    logic [NB_CNT-1:0] cycle_cnt_q;

    logic          bp_raw;
    logic [IW-1:0] bp_raw_idx;
    logic          active, hit, cmd_fire, step_en;
    cmd_e          cmd;

`ifdef PIPELINE_BREAKPOINTS_EN
    bp_match #(.NB(NB), .NB_BP(NB_BP)) u_bp_match (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_bp_we   (i_bp_we),
        .i_bp_idx  (i_bp_idx),
        .i_bp_addr (i_bp_addr),
        .i_bp_en   (i_bp_en),
        .i_pc      (i_pc),
        .o_hit     (bp_raw),
        .o_hit_idx (bp_raw_idx)
    );
`else
    assign bp_raw     = 1'b0;
    assign bp_raw_idx = '0;
    logic unused_bp;
    assign unused_bp = &{1'b0, i_bp_we, i_bp_idx, i_bp_addr, i_bp_en, i_pc};
`endif

    // Handshake: a command is taken on the rising edge where i_cmd_valid && o_cmd_ready;
    // ready depends only on the registered state, never on valid.
    assign cmd      = cmd_e'(i_cmd);
    assign cmd_fire = i_cmd_valid && o_cmd_ready;
    assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
    // skip masks the breakpoint at the resume PC for the first cycle after leaving HALTED.
    assign hit      = active && bp_raw && !skip_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= ST_HALTED;
            reason_q    <= RSN_NONE;
            hit_idx_q   <= '0;
            remain_q    <= '0;
            skip_q      <= 1'b0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            reason_q  <= reason_d;
            hit_idx_q <= hit_idx_d;
            remain_q  <= remain_d;
            skip_q    <= skip_d;
            done_q    <= done_d;
            if (step_en && (cycle_cnt_q != '1)) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        reason_d  = reason_q;
        hit_idx_d = hit_idx_q;
        remain_d  = remain_q;
        skip_d    = skip_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_HALTED: begin
                if (cmd_fire) begin
                    case (cmd)
                        CMD_RUN: begin
                            state_d = ST_RUN;
                            skip_d  = 1'b1;
                        end
                        CMD_STEP: begin
                            state_d  = ST_STEP;
                            remain_d = NB'(1);
                            skip_d   = 1'b1;
                        end
                        CMD_STEP_N: begin
                            if (i_cmd_arg == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d  = ST_STEP;
                                remain_d = i_cmd_arg;
                                skip_d   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN, ST_STEP: begin
                skip_d = 1'b0;
                if ((state_q == ST_STEP) && step_en) begin
                    remain_d = remain_q - 1'b1;
                end
                // Priority: HALT instruction, breakpoint, HALT command, step expiry.
                if (i_halt_instr) begin
                    state_d  = ST_DRAIN;
                    remain_d = NB'(DRAIN_CYCLES);
                end else if (hit) begin
                    state_d   = ST_HALTED;
                    reason_d  = RSN_BP;
                    hit_idx_d = bp_raw_idx;
                    done_d    = 1'b1;
                end else if (cmd_fire && (cmd == CMD_HALT)) begin
                    state_d  = ST_HALTED;
                    reason_d = RSN_USER;
                    done_d   = 1'b1;
                end else if ((state_q == ST_STEP) && (remain_q == NB'(1))) begin
                    state_d  = ST_HALTED;
                    reason_d = RSN_USER;
                    done_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                remain_d = remain_q - 1'b1;
                if (remain_q <= NB'(1)) begin
                    state_d  = ST_FINISHED;
                    reason_d = RSN_END;
                    done_d   = 1'b1;
                end
            end
            ST_FINISHED: ;
            default: state_d = ST_HALTED;
        endcase
    end

    // While draining, instructions already past IF retire but nothing new is fetched.
    always_comb begin
        step_en     = 1'b0;
        o_pc_write  = 1'b0;
        o_cmd_ready = 1'b0;
        unique case (state_q)
            ST_HALTED: o_cmd_ready = 1'b1;
            ST_RUN, ST_STEP: begin
                step_en     = !hit;
                o_pc_write  = !hit;
                o_cmd_ready = 1'b1;
            end
            ST_DRAIN: step_en = 1'b1;
            default: ;
        endcase
    end

    assign o_step        = step_en;
    assign o_state       = state_q;
    assign o_halt_reason = reason_q;
    assign o_bp_hit_idx  = hit_idx_q;
    assign o_cycle_count = cycle_cnt_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl; breakpoint scenarios adapt to PIPELINE_BREAKPOINTS_EN.
module tb_pipeline_run_ctrl;
    import pipeline_run_ctrl_pkg::*;

    localparam int NB           = 32;
    localparam int NB_BP        = 4;
    localparam int NB_CNT       = 32;
    localparam int DRAIN_CYCLES = 4;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_cmd_valid = 1'b0;
    logic [2:0]        i_cmd = '0;
    logic [NB-1:0]     i_cmd_arg = '0;
    logic              o_cmd_ready;
    logic              i_bp_we = 1'b0;
    logic [1:0]        i_bp_idx = '0;
    logic [NB-1:0]     i_bp_addr = '0;
    logic              i_bp_en = 1'b0;
    logic [NB-1:0]     i_pc = '0;
    logic              i_halt_instr = 1'b0;
    logic              o_step;
    logic              o_pc_write;
    logic [2:0]        o_state;
    logic [1:0]        o_halt_reason;
    logic [1:0]        o_bp_hit_idx;
    logic [NB_CNT-1:0] o_cycle_count;
    logic              o_done;

    pipeline_run_ctrl #(
        .NB(NB), .NB_BP(NB_BP), .NB_CNT(NB_CNT), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .i_cmd_arg     (i_cmd_arg),
        .o_cmd_ready   (o_cmd_ready),
        .i_bp_we       (i_bp_we),
        .i_bp_idx      (i_bp_idx),
        .i_bp_addr     (i_bp_addr),
        .i_bp_en       (i_bp_en),
        .i_pc          (i_pc),
        .i_halt_instr  (i_halt_instr),
        .o_step        (o_step),
        .o_pc_write    (o_pc_write),
        .o_state       (o_state),
        .o_halt_reason (o_halt_reason),
        .o_bp_hit_idx  (o_bp_hit_idx),
        .o_cycle_count (o_cycle_count),
        .o_done        (o_done)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    int            n_tests = 0;
    int            n_fail = 0;
    int            nsteps = 0;
    int            done_seen = 0;
    logic          obs_step = 1'b0;
    logic          obs_pcw = 1'b0;
    logic          track_pc = 1'b0;
    logic [NB-1:0] pc_model = '0;
    logic [NB-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: Mealy outputs sampled at negedge, then PC advanced like the IF stage would.
    task automatic cycle();
        @(negedge i_clk);
        obs_step = o_step;
        obs_pcw  = o_pc_write;
        if (obs_step) nsteps++;
        if (track_pc && obs_step && obs_pcw && (exp_q.size() > 0)) begin
            check("sb_fetch_pc", i_pc, exp_q.pop_front());
        end
        @(posedge i_clk);
        #1;
        if (o_done) done_seen++;
        if (track_pc && obs_step && obs_pcw) begin
            pc_model = pc_model + 4;
            i_pc     = pc_model;
        end
    endtask

    task automatic do_reset();
        i_reset      = 1'b0;
        i_cmd_valid  = 1'b0;
        i_halt_instr = 1'b0;
        i_bp_we      = 1'b0;
        track_pc     = 1'b0;
        pc_model     = '0;
        i_pc         = '0;
        cycle();
        cycle();
        i_reset   = 1'b1;
        nsteps    = 0;
        done_seen = 0;
        exp_q.delete();
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [NB-1:0] arg);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        i_cmd_arg   = arg;
        cycle();
        i_cmd_valid = 1'b0;
        i_cmd       = CMD_NOP;
    endtask

    task automatic write_bp(input logic [1:0] idx, input logic [NB-1:0] addr, input logic en);
        i_bp_we   = 1'b1;
        i_bp_idx  = idx;
        i_bp_addr = addr;
        i_bp_en   = en;
        cycle();
        i_bp_we   = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_state == st) begin
                got = 1'b1;
                break;
            end
            cycle();
        end
        check(tag, got, 1'b1);
    endtask

    initial begin
        int drain_cyc;

        // Reset values
        do_reset();
        check("rst_state", o_state, ST_HALTED);
        check("rst_reason", o_halt_reason, RSN_NONE);
        check("rst_bp_idx", o_bp_hit_idx, 0);
        check("rst_count", o_cycle_count, 0);
        check("rst_done", o_done, 0);
        check("rst_step", o_step, 0);
        check("rst_pc_write", o_pc_write, 0);
        check("rst_ready", o_cmd_ready, 1);

        // STEP_N with N=5
        send_cmd(CMD_STEP_N, 5);
        check("stepn_enter", o_state, ST_STEP);
        wait_state("stepn_wait_halt", ST_HALTED, 20);
        check("stepn_done_now", o_done, 1);
        check("stepn_steps", nsteps, 5);
        check("stepn_count", o_cycle_count, 5);
        check("stepn_reason", o_halt_reason, RSN_USER);
        cycle();
        check("stepn_done_pulse", done_seen, 1);
        check("stepn_done_clear", o_done, 0);

        // Breakpoint slot 2 at 0x10, run from PC 0
        do_reset();
        write_bp(2'd1, 32'h08, 1'b0);
        write_bp(2'd2, 32'h10, 1'b1);
        track_pc = 1'b1;
        nsteps   = 0;
`ifdef PIPELINE_BREAKPOINTS_EN
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        send_cmd(CMD_RUN, 0);
        wait_state("bp_wait_halt", ST_HALTED, 20);
        check("bp_steps", nsteps, 4);
        check("bp_gated_step", obs_step, 0);
        check("bp_pc", i_pc, 32'h10);
        check("bp_reason", o_halt_reason, RSN_BP);
        check("bp_idx", o_bp_hit_idx, 2);
        check("bp_count", o_cycle_count, 4);
        check("bp_sb_empty", exp_q.size(), 0);
        exp_q.push_back(32'h10);
        nsteps = 0;
        send_cmd(CMD_STEP, 0);
        wait_state("bp_resume_halt", ST_HALTED, 10);
        check("bp_resume_steps", nsteps, 1);
        check("bp_resume_pc", i_pc, 32'h14);
        check("bp_resume_reason", o_halt_reason, RSN_USER);
        check("bp_resume_count", o_cycle_count, 5);
`else
        for (int i = 0; i < 8; i++) exp_q.push_back(NB'(4 * i));
        send_cmd(CMD_RUN, 0);
        repeat (8) cycle();
        check("nobp_state", o_state, ST_RUN);
        check("nobp_steps", nsteps, 8);
        check("nobp_pc", i_pc, 32'h20);
        check("nobp_reason", o_halt_reason, RSN_NONE);
        check("nobp_idx", o_bp_hit_idx, 0);
        check("nobp_sb_empty", exp_q.size(), 0);
        send_cmd(CMD_HALT, 0);
        check("nobp_halt_state", o_state, ST_HALTED);
`endif

        // HALT command during the 7th run cycle
        do_reset();
        send_cmd(CMD_RUN, 0);
        repeat (6) cycle();
        send_cmd(CMD_HALT, 0);
        check("halt_state", o_state, ST_HALTED);
        check("halt_count", o_cycle_count, 7);
        check("halt_reason", o_halt_reason, RSN_USER);
        check("halt_done", o_done, 1);
        check("halt_step_off", o_step, 0);
        cycle();
        check("halt_done_clear", o_done, 0);
        check("halt_count_hold", o_cycle_count, 7);

        // HALT instruction in the 3rd run cycle, then drain with RUN held on the bus
        do_reset();
        send_cmd(CMD_RUN, 0);
        repeat (2) cycle();
        i_halt_instr = 1'b1;
        cycle();
        i_halt_instr = 1'b0;
        check("drain_state", o_state, ST_DRAIN);
        check("drain_ready", o_cmd_ready, 0);
        drain_cyc   = 0;
        i_cmd_valid = 1'b1;
        i_cmd       = CMD_RUN;
        for (int i = 0; i < 10; i++) begin
            if (o_state != ST_DRAIN) break;
            cycle();
            if (obs_step && !obs_pcw) drain_cyc++;
        end
        check("drain_cycles", drain_cyc, DRAIN_CYCLES);
        check("fin_state", o_state, ST_FINISHED);
        check("fin_reason", o_halt_reason, RSN_END);
        check("fin_done", o_done, 1);
        check("fin_count", o_cycle_count, 7);
        check("fin_ready", o_cmd_ready, 0);
        repeat (3) cycle();
        i_cmd_valid = 1'b0;
        check("fin_sticky", o_state, ST_FINISHED);
        check("fin_no_step", obs_step, 0);
        check("fin_count_hold", o_cycle_count, 7);

        // HALT instruction, breakpoint hit and HALT command in one cycle
        do_reset();
        write_bp(2'd0, 32'h08, 1'b1);
        track_pc = 1'b1;
        send_cmd(CMD_RUN, 0);
        repeat (2) cycle();
        check("prio_pc", i_pc, 32'h08);
        i_halt_instr = 1'b1;
        i_cmd_valid  = 1'b1;
        i_cmd        = CMD_HALT;
        cycle();
        i_halt_instr = 1'b0;
        i_cmd_valid  = 1'b0;
        check("prio_state", o_state, ST_DRAIN);
`ifdef PIPELINE_BREAKPOINTS_EN
        check("prio_step_gated", obs_step, 0);
`else
        check("prio_step_gated", obs_step, 1);
`endif
        cycle();

        // Reset in the middle of DRAIN
        i_reset = 1'b0;
        cycle();
        i_reset = 1'b1;
        check("mid_rst_state", o_state, ST_HALTED);
        check("mid_rst_count", o_cycle_count, 0);
        check("mid_rst_reason", o_halt_reason, RSN_NONE);
        check("mid_rst_step", o_step, 0);
        check("mid_rst_done", o_done, 0);
        pc_model = '0;
        i_pc     = '0;
        nsteps   = 0;
        send_cmd(CMD_RUN, 0);
        repeat (4) cycle();
        check("bp_cleared_state", o_state, ST_RUN);
        check("bp_cleared_steps", nsteps, 4);
        check("bp_cleared_pc", i_pc, 32'h10);
        send_cmd(CMD_HALT, 0);
        cycle();

        // STEP_N with N=0: immediate done, no step
        nsteps    = 0;
        done_seen = 0;
        send_cmd(CMD_STEP_N, 0);
        check("step0_done", o_done, 1);
        check("step0_state", o_state, ST_HALTED);
        cycle();
        check("step0_steps", nsteps, 0);
        check("step0_done_pulse", done_seen, 1);
        check("step0_done_clear", o_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
